// File: rtl/inst_buffer.sv
// Dual-issue instruction queue between fetch and the two decoders (DEPTH-entry circular buffer).
// Optional perf counters are compiled in when IBUF_PERF_EN is defined.
module inst_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  in_valid,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_inst,
  input  logic [11:0] in_is_exception,
  input  logic [83:0] in_excp_cause,
  input  logic [1:0]  in_pre_is_br,
  input  logic [1:0]  in_pre_taken,
  input  logic [63:0] in_pre_addr,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [63:0] out_pc,
  output logic [63:0] out_inst,
  output logic [11:0] out_is_exception,
  output logic [83:0] out_excp_cause,
  output logic [1:0]  out_pre_is_br,
  output logic [1:0]  out_pre_taken,
  output logic [63:0] out_pre_addr,
  input  logic [1:0]  dec_accept
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 32 + 32 + 6 + 42 + 1 + 1 + 32;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [EW-1:0] in_ent [2];
  logic [EW-1:0] rd_ent [2];
  logic [PW-1:0] rd_idx [2];
  logic [PW-1:0] wr_idx [2];
  logic [1:0]    wr_en;
  logic          push_en;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  // Occupancy-derived handshake; no credit is given for a same-cycle pop.
  always_comb begin
    in_ready     = (CW'(DEPTH) - count) >= CW'(2);
    out_valid[0] = count != '0;
    out_valid[1] = count >= CW'(2);
  end

  // Pack fetch slots in program order: a lone slot lands at tail regardless of its index.
  always_comb begin
    push_en   = in_ready && (|in_valid) && !flush;
    push_n    = '0;
    wr_en     = '0;
    wr_idx[0] = tail;
    wr_idx[1] = tail + PW'(in_valid[0]);
    for (int s = 0; s < 2; s++) begin
      in_ent[s] = {in_pc[s*32 +: 32], in_inst[s*32 +: 32], in_is_exception[s*6 +: 6],
                   in_excp_cause[s*42 +: 42], in_pre_is_br[s], in_pre_taken[s],
                   in_pre_addr[s*32 +: 32]};
    end
    if (push_en) begin
      wr_en  = in_valid;
      push_n = 2'(in_valid[0]) + 2'(in_valid[1]);
    end
  end

  // Slot 1 is consumed only together with slot 0.
  always_comb begin
    pop_n = '0;
    if (!flush && dec_accept[0] && out_valid[0]) begin
      pop_n = (dec_accept[1] && out_valid[1]) ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    out_pc           = '0;
    out_inst         = '0;
    out_is_exception = '0;
    out_excp_cause   = '0;
    out_pre_is_br    = '0;
    out_pre_taken    = '0;
    out_pre_addr     = '0;
    rd_idx[0]        = head;
    rd_idx[1]        = head + PW'(1);
    for (int k = 0; k < 2; k++) begin
      rd_ent[k] = mem[rd_idx[k]];
      {out_pc[k*32 +: 32], out_inst[k*32 +: 32], out_is_exception[k*6 +: 6],
       out_excp_cause[k*42 +: 42], out_pre_is_br[k], out_pre_taken[k],
       out_pre_addr[k*32 +: 32]} = rd_ent[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr_en[s]) begin
          mem[wr_idx[s]] <= in_ent[s];
        end
      end
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

`ifdef IBUF_PERF_EN
  // Stall/starvation counters survive flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (!in_ready && (|in_valid)) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if ((count == '0) && !flush) begin
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: queue-level reference model plus negedge monitor.
module tb_inst_buffer;
  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  exc;
    logic [41:0] cause;
    logic        br;
    logic        tk;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic [11:0] in_is_exception;
  logic [83:0] in_excp_cause;
  logic [1:0]  in_pre_is_br;
  logic [1:0]  in_pre_taken;
  logic [63:0] in_pre_addr;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [11:0] out_is_exception;
  logic [83:0] out_excp_cause;
  logic [1:0]  out_pre_is_br;
  logic [1:0]  out_pre_taken;
  logic [63:0] out_pre_addr;
  logic [1:0]  dec_accept;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_empty_cycles;
  logic [31:0] full_m = '0;
  logic [31:0] empty_m = '0;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ent_t exp_q[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_is_exception(in_is_exception), .in_excp_cause(in_excp_cause),
    .in_pre_is_br(in_pre_is_br), .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_is_exception(out_is_exception), .out_excp_cause(out_excp_cause),
    .out_pre_is_br(out_pre_is_br), .out_pre_taken(out_pre_taken),
    .out_pre_addr(out_pre_addr), .dec_accept(dec_accept)
`ifdef IBUF_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t in_slot(input int s);
    ent_t e;
    e.pc    = in_pc[s*32 +: 32];
    e.inst  = in_inst[s*32 +: 32];
    e.exc   = in_is_exception[s*6 +: 6];
    e.cause = in_excp_cause[s*42 +: 42];
    e.br    = in_pre_is_br[s];
    e.tk    = in_pre_taken[s];
    e.addr  = in_pre_addr[s*32 +: 32];
    return e;
  endfunction

  function automatic ent_t out_slot(input int k);
    ent_t e;
    e.pc    = out_pc[k*32 +: 32];
    e.inst  = out_inst[k*32 +: 32];
    e.exc   = out_is_exception[k*6 +: 6];
    e.cause = out_excp_cause[k*42 +: 42];
    e.br    = out_pre_is_br[k];
    e.tk    = out_pre_taken[k];
    e.addr  = out_pre_addr[k*32 +: 32];
    return e;
  endfunction

  // Reference model: FIFO of accepted instructions, updated on each clock edge.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
`ifdef IBUF_PERF_EN
    if (rst) begin
      full_m  = '0;
      empty_m = '0;
    end else begin
      if (sz > int'(DEPTH) - 2 && (|in_valid)) full_m = full_m + 1;
      if (sz == 0 && !flush) empty_m = empty_m + 1;
    end
`endif
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (dec_accept[0] && sz >= 1) begin
        void'(exp_q.pop_front());
        if (dec_accept[1] && sz >= 2) void'(exp_q.pop_front());
      end
      if (sz <= int'(DEPTH) - 2) begin
        if (in_valid[0]) exp_q.push_back(in_slot(0));
        if (in_valid[1]) exp_q.push_back(in_slot(1));
      end
    end
  end

  // Monitor: compare presented head slots and handshake against the model.
  always @(negedge clk) begin
    int sz;
    if (mon_en) begin
      sz = exp_q.size();
      chk("out_valid", 192'(out_valid), 192'({sz >= 2, sz >= 1}));
      chk("in_ready", 192'(in_ready), 192'(sz <= int'(DEPTH) - 2));
      for (int k = 0; k < 2; k++) begin
        if (k < sz) chk($sformatf("slot%0d", k), 192'(out_slot(k)), 192'(exp_q[k]));
      end
`ifdef IBUF_PERF_EN
      chk("perf_full", 192'(perf_full_cycles), 192'(full_m));
      chk("perf_empty", 192'(perf_empty_cycles), 192'(empty_m));
`endif
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] acc, input logic fl,
                      input logic rs, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid        = v;
    dec_accept      = acc;
    flush           = fl;
    rst             = rs;
    in_pc           = {pc1, pc0};
    in_inst         = {$urandom, $urandom};
    in_is_exception = 12'($urandom);
    in_excp_cause   = {20'($urandom), $urandom, $urandom};
    in_pre_is_br    = 2'($urandom);
    in_pre_taken    = 2'($urandom);
    in_pre_addr     = {$urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid   = '0;
    dec_accept = '0;
    flush      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic push(input logic [1:0] v, input logic [1:0] acc);
    step(v, acc, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; dec_accept = '0;
    in_pc = '0; in_inst = '0; in_is_exception = '0; in_excp_cause = '0;
    in_pre_is_br = '0; in_pre_taken = '0; in_pre_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_out_pc", 192'(out_pc), 192'(0));
    chk("rst_out_inst", 192'(out_inst), 192'(0));
    chk("rst_out_cause", 192'(out_excp_cause), 192'(0));

    // Two-wide push into empty buffer
    step(2'b11, 2'b00, 1'b0, 1'b0, 32'h1c00_0000, 32'h1c00_0004);
    @(negedge clk);
    chk("t1_valid", 192'(out_valid), 192'(2'b11));
    chk("t1_pc", 192'(out_pc), 192'(64'h1c00_0004_1c00_0000));

    // Lone slot1 packs into slot0 position
    step(2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step(2'b10, 2'b00, 1'b0, 1'b0, 32'h1c00_0010, 32'h1c00_0014);
    @(negedge clk);
    chk("t2_valid", 192'(out_valid), 192'(2'b01));
    chk("t2_pc0", 192'(out_pc[31:0]), 192'(32'h1c00_0014));

    // Fill to full, then a dropped push, then drain
    step(2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    repeat (4) push(2'b11, 2'b00);
    @(negedge clk);
    chk("t3_full_ready", 192'(in_ready), 192'(0));
    push(2'b11, 2'b00);
    @(negedge clk);
    chk("t3_drop_ready", 192'(in_ready), 192'(0));
    repeat (3) push(2'b00, 2'b11);
    @(negedge clk);
    chk("t3_two_left", 192'(out_valid), 192'(2'b11));
    push(2'b00, 2'b11);
    @(negedge clk);
    chk("t3_drained", 192'(out_valid), 192'(2'b00));

    // count=7: push refused, pop two -> 5
    repeat (3) push(2'b11, 2'b00);
    push(2'b01, 2'b00);
    @(negedge clk);
    chk("t4_ready7", 192'(in_ready), 192'(0));
    push(2'b11, 2'b11);
    @(negedge clk);
    chk("t4_ready5", 192'(in_ready), 192'(1));

    // Flush wins over push and pop
    push(2'b11, 2'b11);
    step(2'b11, 2'b11, 1'b1, 1'b0, $urandom, $urandom);
    @(negedge clk);
    chk("t5_valid", 192'(out_valid), 192'(2'b00));
    chk("t5_ready", 192'(in_ready), 192'(1));

    // accept=10 pops nothing
    step(2'b11, 2'b00, 1'b0, 1'b0, 32'h1c00_0100, 32'h1c00_0104);
    push(2'b00, 2'b10);
    @(negedge clk);
    chk("t6_head", 192'(out_pc[31:0]), 192'(32'h1c00_0100));
    chk("t6_valid", 192'(out_valid), 192'(2'b11));

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      step(2'($urandom), 2'($urandom), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 399) == 0), $urandom, $urandom);
    end
    push(2'b00, 2'b00);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
